// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Opcode values and sequencer state encoding shared by the
//                cpu fetch/decode sequencer and its decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Opcodes, upper nibble of the 8-bit instruction {op, im}
    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_MOV_AC = 4'b0010;
    localparam logic [3:0] OP_ADD_C  = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_MOV_BC = 4'b0110;
    localparam logic [3:0] OP_ADD_D  = 4'b0111;
    localparam logic [3:0] OP_HLT    = 4'b1000;
    localparam logic [3:0] OP_MOV_CA = 4'b1001;
    localparam logic [3:0] OP_NOP_A  = 4'b1010;
    localparam logic [3:0] OP_MOV_DB = 4'b1011;
    localparam logic [3:0] OP_NOP_C  = 4'b1100;
    localparam logic [3:0] OP_NOP_D  = 4'b1101;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/cpu_decode.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_decode
//  Description : Combinational opcode decoder: selector index, register
//                write mask, immediate suppression and control-flow flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [3:0] op,
    output logic [1:0] sel,
    output logic [3:0] load_mask,
    output logic       im_zero,
    output logic       is_add,
    output logic       is_jmp,
    output logic       is_jnc,
    output logic       is_hlt
);

    // Opcode table lookup; unlisted codes behave as no-operation
    always_comb begin
        sel       = 2'b00;
        load_mask = 4'b0000;
        im_zero   = 1'b0;
        is_add    = 1'b0;
        is_jmp    = 1'b0;
        is_jnc    = 1'b0;
        is_hlt    = 1'b0;
        case (op)
            OP_ADD_A:  begin sel = 2'b00; load_mask = 4'b0001; is_add = 1'b1; end
            OP_ADD_B:  begin sel = 2'b01; load_mask = 4'b0010; is_add = 1'b1; end
            OP_ADD_C:  begin sel = 2'b10; load_mask = 4'b0100; is_add = 1'b1; end
            OP_ADD_D:  begin sel = 2'b11; load_mask = 4'b1000; is_add = 1'b1; end
            OP_MOV_AB: begin sel = 2'b01; load_mask = 4'b0001; im_zero = 1'b1; end
            OP_MOV_BA: begin sel = 2'b00; load_mask = 4'b0010; im_zero = 1'b1; end
            OP_MOV_AC: begin sel = 2'b10; load_mask = 4'b0001; im_zero = 1'b1; end
            OP_MOV_BC: begin sel = 2'b10; load_mask = 4'b0010; im_zero = 1'b1; end
            OP_MOV_CA: begin sel = 2'b00; load_mask = 4'b0100; im_zero = 1'b1; end
            OP_MOV_DB: begin sel = 2'b01; load_mask = 4'b1000; im_zero = 1'b1; end
            OP_JMP:    is_jmp = 1'b1;
            OP_JNC:    is_jnc = 1'b1;
            OP_HLT:    is_hlt = 1'b1;
            default:   ;
        endcase
    end

endmodule : cpu_decode
`default_nettype wire

// File: rtl/cpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_seq_ctrl
//  Description : Instruction fetch/decode sequencer. Fetches {op, im} from
//                the instruction ROM over req/ack, drives the datapath's
//                selector, load strobes and immediate, and owns pc and carry.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int PC_W     = 4,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            run,
    output logic [PC_W-1:0] rom_addr,
    output logic            rom_req,
    input  logic            rom_ack,
    input  logic [7:0]      rom_data,
    input  logic            alu_carry,
    output logic            select_a,
    output logic            select_b,
    output logic            load0,
    output logic            load1,
    output logic            load2,
    output logic            load3,
    output logic [3:0]      im,
    output logic            carry,
    output logic            halted
);

    localparam logic [PC_W-1:0] c_reset_pc = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] c_pc_one   = PC_W'(1);

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_instr;
    logic            r_carry;
    logic            r_rom_req;
    logic [3:0]      r_load;
    logic [1:0]      r_sel;
    logic [3:0]      r_im;
    logic            r_halted;

    logic [3:0]      w_op;
    logic [1:0]      w_sel;
    logic [3:0]      w_load_mask;
    logic            w_im_zero;
    logic            w_is_add;
    logic            w_is_jmp;
    logic            w_is_jnc;
    logic            w_is_hlt;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_jmp_tgt;

    // In WAIT the incoming ROM word is decoded so the datapath controls are
    // ready in EXEC; otherwise the latched instruction drives the decoder.
    assign w_op      = (r_state == ST_WAIT) ? rom_data[7:4] : r_instr[7:4];
    assign w_pc_inc  = r_pc + c_pc_one;
    assign w_jmp_tgt = PC_W'(r_instr[3:0]);

    cpu_decode u_decode (
        .op        (w_op),
        .sel       (w_sel),
        .load_mask (w_load_mask),
        .im_zero   (w_im_zero),
        .is_add    (w_is_add),
        .is_jmp    (w_is_jmp),
        .is_jnc    (w_is_jnc),
        .is_hlt    (w_is_hlt)
    );

    // Sequencer FSM with registered controls; load strobes live only in EXEC
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state   <= ST_IDLE;
            r_pc      <= c_reset_pc;
            r_instr   <= 8'h00;
            r_carry   <= 1'b0;
            r_rom_req <= 1'b0;
            r_load    <= 4'b0000;
            r_sel     <= 2'b00;
            r_im      <= 4'h0;
            r_halted  <= 1'b0;
        end else begin
            r_load <= 4'b0000;
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_state   <= ST_FETCH;
                        r_rom_req <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (rom_ack) begin
                        r_instr   <= rom_data;
                        r_sel     <= w_sel;
                        r_im      <= w_im_zero ? 4'h0 : rom_data[3:0];
                        r_load    <= w_load_mask;
                        r_rom_req <= 1'b0;
                        r_state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_is_hlt) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        if (w_is_jmp || (w_is_jnc && !r_carry)) begin
                            r_pc <= w_jmp_tgt;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                        r_carry <= w_is_add ? alu_carry : 1'b0;
                        if (run) begin
                            r_state   <= ST_FETCH;
                            r_rom_req <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rom_addr = r_pc;
    assign rom_req  = r_rom_req;
    assign select_a = r_sel[0];
    assign select_b = r_sel[1];
    assign load0    = r_load[0];
    assign load1    = r_load[1];
    assign load2    = r_load[2];
    assign load3    = r_load[3];
    assign im       = r_im;
    assign carry    = r_carry;
    assign halted   = r_halted;

endmodule : cpu_seq_ctrl
`default_nettype wire

// File: tb/tb_cpu_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_seq_ctrl
//  Description : Self-checking bench for cpu_seq_ctrl: ROM responder with
//                variable ack latency and an instruction-level reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_seq_ctrl;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       run = 1'b0;
    logic [3:0] rom_addr;
    logic       rom_req;
    logic       rom_ack = 1'b0;
    logic [7:0] rom_data = 8'h00;
    logic       alu_carry = 1'b0;
    logic       select_a, select_b;
    logic       load0, load1, load2, load3;
    logic [3:0] im;
    logic       carry, halted;

    cpu_seq_ctrl #(.PC_W(4), .RESET_PC(0)) u_dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .run       (run),
        .rom_addr  (rom_addr),
        .rom_req   (rom_req),
        .rom_ack   (rom_ack),
        .rom_data  (rom_data),
        .alu_carry (alu_carry),
        .select_a  (select_a),
        .select_b  (select_b),
        .load0     (load0),
        .load1     (load1),
        .load2     (load2),
        .load3     (load3),
        .im        (im),
        .carry     (carry),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [16];
    int n_checks = 0;
    int n_errors = 0;

    // Reference state: architectural registers plus handshake phase tracking
    logic [3:0] m_pc;
    logic       m_carry, m_halted;
    logic       m_req, m_fetch, m_exec;
    logic [7:0] m_instr;
    int         wait_cnt, cur_delay;

    // Stimulus knobs
    int fixed_delay = -1;
    int run_pct     = 100;
    int carry_mode  = 2;
    bit stray       = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Opcode table: {sel_b, sel_a, load3..load0}; zero for non-writing ops
    function automatic logic [5:0] ref_ctl(input logic [3:0] op);
        case (op)
            4'b0000: return {2'b00, 4'b0001};
            4'b0101: return {2'b01, 4'b0010};
            4'b0011: return {2'b10, 4'b0100};
            4'b0111: return {2'b11, 4'b1000};
            4'b0001: return {2'b01, 4'b0001};
            4'b0100: return {2'b00, 4'b0010};
            4'b0010: return {2'b10, 4'b0001};
            4'b0110: return {2'b10, 4'b0010};
            4'b1001: return {2'b00, 4'b0100};
            4'b1011: return {2'b01, 4'b1000};
            default: return 6'b0;
        endcase
    endfunction

    function automatic bit ref_is_add(input logic [3:0] op);
        return (op == 4'h0) || (op == 4'h5) || (op == 4'h3) || (op == 4'h7);
    endfunction

    function automatic void model_reset();
        m_pc = 4'd0; m_carry = 1'b0; m_halted = 1'b0;
        m_req = 1'b0; m_fetch = 1'b0; m_exec = 1'b0;
        m_instr = 8'h00; wait_cnt = 0; cur_delay = 0;
    endfunction

    // Assert reset now and check outputs return to reset values at once
    task automatic reset_now();
        n_reset = 1'b0;
        run     = 1'b0;
        rom_ack = 1'b0;
        #1;
        model_reset();
        check_val("rst_req",    rom_req, 0);
        check_val("rst_pc",     rom_addr, 0);
        check_val("rst_loads",  {load3, load2, load1, load0}, 0);
        check_val("rst_halted", halted, 0);
        check_val("rst_carry",  carry, 0);
    endtask

    task automatic do_reset();
        reset_now();
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
    endtask

    // One clock: check observed outputs, drive inputs, advance the reference
    task automatic cycle();
        logic [5:0] ctl;
        logic [3:0] op;
        bit         acc;
        @(negedge clk);
        ctl = ref_ctl(m_instr[7:4]);
        check_val("rom_req", rom_req, m_req);
        check_val("pc", rom_addr, m_pc);
        check_val("carry", carry, m_carry);
        check_val("halted", halted, m_halted);
        check_val("loads", {load3, load2, load1, load0}, m_exec ? ctl[3:0] : 4'b0);
        if (ctl[3:0] != 4'b0) begin
            check_val("select", {select_b, select_a}, ctl[5:4]);
            check_val("im", im, ref_is_add(m_instr[7:4]) ? m_instr[3:0] : 4'h0);
        end

        run       = ($urandom_range(0, 99) < run_pct);
        alu_carry = (carry_mode == 2) ? 1'($urandom_range(0, 1)) : (carry_mode == 1);
        acc       = 1'b0;
        if (m_req && !m_fetch) begin
            if (wait_cnt >= cur_delay) acc = 1'b1;
            else wait_cnt++;
            rom_ack  = acc;
            rom_data = acc ? rom[m_pc] : 8'($urandom);
        end else begin
            rom_ack  = stray && ($urandom_range(0, 1) == 1);
            rom_data = 8'($urandom);
        end

        if (m_exec) begin
            op = m_instr[7:4];
            m_exec = 1'b0;
            if (op == 4'h8) begin
                m_halted = 1'b1;
                m_req = 1'b0;
            end else begin
                if (op == 4'hF || (op == 4'hE && !m_carry)) m_pc = m_instr[3:0];
                else m_pc = m_pc + 4'd1;
                m_carry = ref_is_add(op) ? alu_carry : 1'b0;
                m_req   = run;
                m_fetch = run;
            end
        end else if (m_halted) begin
            m_req = 1'b0;
        end else if (m_req) begin
            if (m_fetch) begin
                m_fetch   = 1'b0;
                wait_cnt  = 0;
                cur_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
            end else if (acc) begin
                m_req   = 1'b0;
                m_exec  = 1'b1;
                m_instr = rom[m_pc];
            end
        end else begin
            m_req   = run;
            m_fetch = run;
        end
    endtask

    task automatic fill_rom(input logic [7:0] val);
        for (int i = 0; i < 16; i++) rom[i] = val;
    endtask

    initial begin
        model_reset();
        fill_rom(8'hA0);

        // Reset and idle with run low
        do_reset();
        run_pct = 0;
        repeat (10) cycle();

        // ADD A,3 with same-cycle ack
        fill_rom(8'hA0);
        rom[0] = 8'h03;
        fixed_delay = 0; run_pct = 100; carry_mode = 2;
        do_reset();
        repeat (8) cycle();

        // Carry set by ADD, JNC not taken, then cleared carry with JNC taken
        fill_rom(8'hA0);
        rom[0] = 8'h0F; rom[1] = 8'hE5;
        carry_mode = 1;
        do_reset();
        repeat (8) cycle();
        check_val("jnc_not_taken_pc", rom_addr, 2);
        carry_mode = 0;
        do_reset();
        repeat (8) cycle();
        check_val("jnc_taken_pc", rom_addr, 5);

        // JMP targets and pc wrap 15 -> 0
        fill_rom(8'hA0);
        rom[0] = 8'hF7; rom[7] = 8'hFF;
        carry_mode = 2;
        do_reset();
        repeat (40) cycle();

        // Long ack latency with stray acks outside WAIT
        fixed_delay = 4; stray = 1'b1;
        do_reset();
        repeat (40) cycle();

        // Reset asserted while waiting for the ROM
        fill_rom(8'hA0);
        fixed_delay = 0; stray = 1'b0;
        do_reset();
        repeat (10) cycle();
        fixed_delay = 6;
        for (int i = 0; i < 50 && !(m_req && !m_fetch); i++) cycle();
        check_val("reach_wait", {31'd0, m_req && !m_fetch}, 1);
        cycle();
        do_reset();
        repeat (5) cycle();

        // HLT: halted, no further fetches
        fill_rom(8'hA0);
        rom[0] = 8'h80;
        fixed_delay = 0; stray = 1'b1;
        do_reset();
        repeat (25) cycle();
        check_val("halt_final", halted, 1);

        // Randomized programs, latencies and run toggling
        fixed_delay = -1; run_pct = 80;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) begin
                rom[i] = 8'($urandom);
                if (r < 5 && rom[i][7:4] == 4'h8) rom[i][7:4] = 4'hA;
            end
            do_reset();
            repeat (150) cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_cpu_seq_ctrl
`default_nettype wire
